lcm_report_gen: RTL and testbench

//  Local-control-management status reporter: builds a fixed 4-word TSMP state-report frame
//  and hands it to the downstream report/PTP mux over its req/ack port (iv_data_lcm side).

---
 rtl/lcm_report_gen_pkg.sv | 44 ++++
 rtl/lcm_report_timer.sv | 43 ++++
 rtl/lcm_report_gen.sv | 100 ++++++++++
 tb/tb_lcm_report_gen.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_report_gen_pkg.sv
// Shared TSMP constants, frame header codes, FSM encodings and the frame word builder
// for the local-control-management state reporter.
package lcm_report_gen_pkg;

   localparam logic [15:0] TSMP_ETHERTYPE            = 16'hFF01;
   localparam logic [7:0]  TSMP_SUBTYPE_STATE_REPORT = 8'h05;

   localparam logic [1:0]  HDR_HEAD = 2'b01;
   localparam logic [1:0]  HDR_BODY = 2'b11;
   localparam logic [1:0]  HDR_TAIL = 2'b10;

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_REQ  = 2'd1;
   localparam logic [1:0]  ST_SEND = 2'd2;

   typedef struct packed {
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [11:0] dev_id;
      logic [31:0] tx_pkt_cnt;
      logic [31:0] rx_pkt_cnt;
      logic [31:0] err_cnt;
      logic [31:0] local_time;
   } snapshot_t;

   // Invalid-byte field is always 0: every word, including the tail, carries 16 valid bytes.
   function automatic logic [133:0] build_word(input logic [1:0]  idx,
                                               input snapshot_t   snap,
                                               input logic [7:0]  seq,
                                               input logic [15:0] ethertype,
                                               input logic [7:0]  subtype);
      logic [133:0] word;
      word = '0;
      case (idx)
         2'd0:    word = {HDR_HEAD, 4'h0, snap.dmac, snap.smac, ethertype, subtype, seq};
         2'd1:    word = {HDR_BODY, 4'h0, snap.tx_pkt_cnt, snap.rx_pkt_cnt,
                          snap.err_cnt, snap.local_time};
         2'd2:    word = {HDR_BODY, 4'h0, snap.dev_id, 116'd0};
         default: word = {HDR_TAIL, 4'h0, 128'd0};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/lcm_report_timer.sv
// Report period counter and the single coalescing "report pending" flag.
module lcm_report_timer
#(
   parameter int PERIOD_W = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_report_en,
   input  logic [PERIOD_W-1:0] iv_report_period,
   input  logic                i_report_trigger,
   input  logic                i_pending_clr,
   output logic                o_pending
);

   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] period_eff;
   logic                run;
   logic                tc;

   // The period is sampled whenever the count restarts, so a change lands at the next wrap.
   assign run        = i_report_en && (iv_report_period != '0);
   assign period_eff = (cnt == '0) ? iv_report_period : period_q;
   assign tc         = run && (cnt == period_eff - PERIOD_W'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt       <= '0;
         period_q  <= '0;
         o_pending <= 1'b0;
      end else begin
         if (cnt == '0)
            period_q <= iv_report_period;
         if (!run || tc)
            cnt <= '0;
         else
            cnt <= cnt + PERIOD_W'(1);
         // A new event in the clearing cycle survives and schedules the next report.
         o_pending <= tc | i_report_trigger | (o_pending & ~i_pending_clr);
      end
   end

endmodule

// File: rtl/lcm_report_gen.sv
// LCM state reporter: snapshots status when a report is pending, requests the mux,
// then streams the fixed 4-word TSMP frame one word per cycle after the grant.
//  state   | meaning
//  IDLE    | no frame in flight, waiting for pending
//  REQ     | snapshot taken, request held until ack
//  SEND    | words 0..3 on the bus, then one cleanup cycle
module lcm_report_gen
   import lcm_report_gen_pkg::*;
#(
   parameter int          PERIOD_W  = 32,
   parameter logic [15:0] ETHERTYPE = TSMP_ETHERTYPE,
   parameter logic [7:0]  SUBTYPE   = TSMP_SUBTYPE_STATE_REPORT
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_report_en,
   input  logic [PERIOD_W-1:0] iv_report_period,
   input  logic                i_report_trigger,
   input  logic [47:0]         iv_dmac,
   input  logic [47:0]         iv_smac,
   input  logic [11:0]         iv_dev_id,
   input  logic [31:0]         iv_tx_pkt_cnt,
   input  logic [31:0]         iv_rx_pkt_cnt,
   input  logic [31:0]         iv_err_cnt,
   input  logic [31:0]         iv_local_time,
   output logic                o_data_lcm_req,
   input  logic                i_data_lcm_ack,
   output logic [133:0]        ov_data_lcm,
   output logic                o_report_busy,
   output logic [15:0]         ov_report_cnt
);

   logic [1:0]  state;
   logic [1:0]  word_idx;
   logic [7:0]  seq;
   snapshot_t   snap;
   logic        pending;
   logic        pending_clr;

   assign pending_clr = (state == ST_IDLE) && pending;

   lcm_report_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_report_en      (i_report_en),
      .iv_report_period (iv_report_period),
      .i_report_trigger (i_report_trigger),
      .i_pending_clr    (pending_clr),
      .o_pending        (pending)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= ST_IDLE;
         word_idx       <= 2'd0;
         seq            <= 8'd0;
         snap           <= '0;
         o_data_lcm_req <= 1'b0;
         ov_data_lcm    <= '0;
         o_report_busy  <= 1'b0;
         ov_report_cnt  <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  snap <= '{dmac: iv_dmac, smac: iv_smac, dev_id: iv_dev_id,
                            tx_pkt_cnt: iv_tx_pkt_cnt, rx_pkt_cnt: iv_rx_pkt_cnt,
                            err_cnt: iv_err_cnt, local_time: iv_local_time};
                  o_data_lcm_req <= 1'b1;
                  o_report_busy  <= 1'b1;
                  state          <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_data_lcm_ack) begin
                  o_data_lcm_req <= 1'b0;
                  ov_data_lcm    <= build_word(2'd0, snap, seq, ETHERTYPE, SUBTYPE);
                  word_idx       <= 2'd1;
                  state          <= ST_SEND;
               end
            end
            ST_SEND: begin
               // word_idx wraps to 0 after the tail, marking the cleanup cycle.
               if (word_idx == 2'd0) begin
                  ov_data_lcm   <= '0;
                  seq           <= seq + 8'd1;
                  ov_report_cnt <= ov_report_cnt + 16'd1;
                  o_report_busy <= 1'b0;
                  state         <= ST_IDLE;
               end else begin
                  ov_data_lcm <= build_word(word_idx, snap, seq, ETHERTYPE, SUBTYPE);
                  word_idx    <= word_idx + 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_report_gen.sv
// Self-checking bench for lcm_report_gen: expected frames are queued by the stimulus
// and a monitor compares every frame the DUT puts on the bus.
module tb_lcm_report_gen;

   typedef logic [3:0][133:0] frame_t;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_report_en;
   logic [31:0]  iv_report_period;
   logic         i_report_trigger;
   logic [47:0]  iv_dmac;
   logic [47:0]  iv_smac;
   logic [11:0]  iv_dev_id;
   logic [31:0]  iv_tx_pkt_cnt;
   logic [31:0]  iv_rx_pkt_cnt;
   logic [31:0]  iv_err_cnt;
   logic [31:0]  iv_local_time;
   logic         o_data_lcm_req;
   logic         i_data_lcm_ack;
   logic [133:0] ov_data_lcm;
   logic         o_report_busy;
   logic [15:0]  ov_report_cnt;

   logic         ack_resp = 1'b0;
   logic         ack_spur = 1'b0;
   int           ack_dly  = 1;
   int           tests_run = 0;
   int           tests_failed = 0;
   int           cyc = 0;
   logic [7:0]   model_seq = 8'd0;
   frame_t       exp_q[$];
   frame_t       mon_cur;
   int           mon_idx = 0;
   bit           mon_coll = 1'b0;

   assign i_data_lcm_ack = ack_resp | ack_spur;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   lcm_report_gen dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_report_en      (i_report_en),
      .iv_report_period (iv_report_period),
      .i_report_trigger (i_report_trigger),
      .iv_dmac          (iv_dmac),
      .iv_smac          (iv_smac),
      .iv_dev_id        (iv_dev_id),
      .iv_tx_pkt_cnt    (iv_tx_pkt_cnt),
      .iv_rx_pkt_cnt    (iv_rx_pkt_cnt),
      .iv_err_cnt       (iv_err_cnt),
      .iv_local_time    (iv_local_time),
      .o_data_lcm_req   (o_data_lcm_req),
      .i_data_lcm_ack   (i_data_lcm_ack),
      .ov_data_lcm      (ov_data_lcm),
      .o_report_busy    (o_report_busy),
      .ov_report_cnt    (ov_report_cnt)
   );

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference frame straight from the field layout of a state report.
   function automatic frame_t make_frame(input logic [7:0] seq);
      frame_t f;
      f[0] = {2'b01, 4'h0, iv_dmac, iv_smac, 16'hFF01, 8'h05, seq};
      f[1] = {2'b11, 4'h0, iv_tx_pkt_cnt, iv_rx_pkt_cnt, iv_err_cnt, iv_local_time};
      f[2] = {2'b11, 4'h0, iv_dev_id, 116'd0};
      f[3] = {2'b10, 4'h0, 128'd0};
      return f;
   endfunction

   task automatic push_exp();
      exp_q.push_back(make_frame(model_seq));
      model_seq = model_seq + 8'd1;
   endtask

   task automatic rand_status();
      iv_dmac       = {16'($urandom()), $urandom()};
      iv_smac       = {16'($urandom()), $urandom()};
      iv_dev_id     = 12'($urandom());
      iv_tx_pkt_cnt = $urandom();
      iv_rx_pkt_cnt = $urandom();
      iv_err_cnt    = $urandom();
      iv_local_time = $urandom();
   endtask

   task automatic pulse_trigger();
      i_report_trigger = 1'b1;
      @(negedge i_clk);
      i_report_trigger = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl, input int max, input string name);
      int n = 0;
      while (o_report_busy !== lvl && n < max) begin
         @(negedge i_clk);
         n++;
      end
      if (o_report_busy !== lvl) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: busy=%b after %0d cycles, required %b", name, o_report_busy, n, lvl);
      end
   endtask

   task automatic wait_hdr(input logic [1:0] hdr, input int max, input string name);
      int n = 0;
      while (ov_data_lcm[133:132] !== hdr && n < max) begin
         @(negedge i_clk);
         n++;
      end
      if (ov_data_lcm[133:132] !== hdr) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: hdr=%b after %0d cycles, required %b", name, ov_data_lcm[133:132], n, hdr);
      end
   endtask

   task automatic wait_req_rise(input int max, output int at);
      logic prev;
      int   n = 0;
      prev = o_data_lcm_req;
      at   = -1;
      while (n < max) begin
         @(negedge i_clk);
         n++;
         if (o_data_lcm_req && !prev) begin
            at = cyc;
            return;
         end
         prev = o_data_lcm_req;
      end
      tests_run++;
      tests_failed++;
      $display("FAIL req_rise: no rising edge within %0d cycles, required one", max);
   endtask

   task automatic send_one();
      rand_status();
      push_exp();
      pulse_trigger();
      wait_busy(1'b1, 10, "send_busy_hi");
      wait_busy(1'b0, 50, "send_busy_lo");
   endtask

   // Mux model: grants a pending request ack_dly cycles after it is first seen.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_data_lcm_req && !i_rst) begin
            repeat (ack_dly - 1) @(negedge i_clk);
            ack_resp = 1'b1;
            @(negedge i_clk);
            ack_resp = 1'b0;
         end
      end
   end

   // Monitor: every frame on the bus is compared word by word with the next queued frame.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            mon_coll = 1'b0;
         end else if (!mon_coll) begin
            if (ov_data_lcm !== '0) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_frame: got %h expected no frame", ov_data_lcm);
               end else begin
                  mon_cur = exp_q.pop_front();
                  check("word0", ov_data_lcm, mon_cur[0]);
                  mon_idx  = 1;
                  mon_coll = 1'b1;
               end
            end
         end else begin
            check($sformatf("word%0d", mon_idx), ov_data_lcm, mon_cur[mon_idx]);
            mon_idx++;
            if (mon_idx == 4) mon_coll = 1'b0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      int          t [3];
      logic [15:0] c0;

      i_rst = 1'b1;
      i_report_en = 1'b0;
      iv_report_period = 32'd0;
      i_report_trigger = 1'b0;
      rand_status();
      repeat (3) @(negedge i_clk);
      check("rst_data", ov_data_lcm, 134'd0);
      check("rst_req", 134'(o_data_lcm_req), 134'd0);
      check("rst_busy", 134'(o_report_busy), 134'd0);
      check("rst_cnt", 134'(ov_report_cnt), 134'd0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // 1: on-demand report with a slow grant
      ack_dly = 3;
      rand_status();
      push_exp();
      pulse_trigger();
      n = 0;
      while (!o_data_lcm_req && n < 10) begin
         @(negedge i_clk);
         n++;
      end
      n = 0;
      while (o_data_lcm_req && n < 20) begin
         n++;
         @(negedge i_clk);
      end
      check("req_high_cycles", 134'(n), 134'(3));
      check("ack_to_word0_hdr", 134'(ov_data_lcm[133:132]), 134'(2'b01));
      wait_busy(1'b0, 20, "t1_busy_lo");
      check("t1_report_cnt", 134'(ov_report_cnt), 134'(1));
      check("t1_busy", 134'(o_report_busy), 134'd0);
      check("t1_idle_data", ov_data_lcm, 134'd0);

      // 2: periodic reports every 100 cycles
      ack_dly = 1;
      rand_status();
      repeat (3) push_exp();
      iv_report_period = 32'd100;
      i_report_en = 1'b1;
      for (int k = 0; k < 3; k++) wait_req_rise(250, t[k]);
      i_report_en = 1'b0;
      check("period_gap0", 134'(t[1] - t[0]), 134'(100));
      check("period_gap1", 134'(t[2] - t[1]), 134'(100));
      wait_busy(1'b0, 20, "t2_busy_lo");

      // 3: status changes after the snapshot do not leak into the frame
      iv_report_period = 32'd0;
      ack_dly = 2;
      rand_status();
      iv_tx_pkt_cnt = 32'h1111_1111;
      push_exp();
      pulse_trigger();
      n = 0;
      while (!o_data_lcm_req && n < 10) begin
         @(negedge i_clk);
         n++;
      end
      iv_tx_pkt_cnt = 32'h2222_2222;
      wait_busy(1'b0, 30, "t3_busy_lo");

      // 4: triggers during SEND coalesce; enable with period 0 stays silent
      c0 = ov_report_cnt;
      i_report_en = 1'b1;
      ack_dly = int'($urandom_range(1, 4));
      rand_status();
      push_exp();
      pulse_trigger();
      wait_hdr(2'b01, 20, "t4_word0");
      rand_status();
      push_exp();
      i_report_trigger = 1'b1;
      @(negedge i_clk);
      i_report_trigger = 1'b0;
      @(negedge i_clk);
      i_report_trigger = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_report_trigger = 1'b0;
      wait_busy(1'b1, 10, "t4_busy_hi");
      wait_busy(1'b0, 30, "t4_busy_lo");
      repeat (300) @(negedge i_clk);
      check("coalesce_cnt", 134'(ov_report_cnt), 134'(c0 + 16'd2));
      check("coalesce_queue", 134'(exp_q.size()), 134'd0);

      // 5: 256 frames wrap seq; a stray ack in IDLE changes nothing
      i_report_en = 1'b0;
      ack_dly = 1;
      c0 = ov_report_cnt;
      for (int k = 0; k < 256; k++) send_one();
      check("wrap_cnt", 134'(ov_report_cnt), 134'(c0 + 16'd256));
      c0 = ov_report_cnt;
      @(negedge i_clk);
      ack_spur = 1'b1;
      @(negedge i_clk);
      ack_spur = 1'b0;
      check("idle_ack_data", ov_data_lcm, 134'd0);
      check("idle_ack_req", 134'(o_data_lcm_req), 134'd0);
      check("idle_ack_busy", 134'(o_report_busy), 134'd0);
      check("idle_ack_cnt", 134'(ov_report_cnt), 134'(c0));

      // 6: reset in the middle of a frame
      rand_status();
      push_exp();
      pulse_trigger();
      wait_hdr(2'b01, 20, "t6_word0");
      @(negedge i_clk);
      i_rst = 1'b1;
      model_seq = 8'd0;
      @(negedge i_clk);
      check("midrst_data", ov_data_lcm, 134'd0);
      check("midrst_req", 134'(o_data_lcm_req), 134'd0);
      check("midrst_busy", 134'(o_report_busy), 134'd0);
      check("midrst_cnt", 134'(ov_report_cnt), 134'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      send_one();
      repeat (3) @(negedge i_clk);
      check("post_rst_cnt", 134'(ov_report_cnt), 134'(1));
      check("final_queue", 134'(exp_q.size()), 134'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
